// File: rtl/dtree_pkg.sv
// Shared definitions for the dtree classifier and its sample feeder.
package dtree_pkg;

    // Classifier input sample width; the feeder defaults to the same value.
    localparam int IN_WIDTH_DEFAULT = 10;

    // Classifier-side constants, kept here so both blocks agree on them.
    localparam int DTREE_IN_WIDTH = IN_WIDTH_DEFAULT;

    // Feeder defaults.
    localparam int FEEDER_DEPTH_DEFAULT = 16;
    localparam int FEEDER_PRIME_DEFAULT = 4;

    // Feeder control states: FILL primes the FIFO, STREAM serves ready pulses.
    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/dtree_sync_fifo.sv
// Circular single-clock FIFO: storage, wrapping pointers and an explicit
// occupancy counter. Pushes while full and pops while empty are ignored here;
// the caller decides what those events mean. Read data is presented
// combinationally from the head slot and registered by the consumer.
module dtree_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Storage write; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        end
    end

    // Occupancy: unchanged when a push and a pop land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/dtree_sample_feeder.sv
// Feeds buffered ADC samples to the dtree classifier, one per ready edge.
// Primes the FIFO before streaming, re-primes after an underrun, and keeps
// sticky underrun/overflow flags until reset.
module dtree_sample_feeder
    import dtree_pkg::*;
#(
    parameter int IN_WIDTH = IN_WIDTH_DEFAULT,
    parameter int DEPTH    = FEEDER_DEPTH_DEFAULT,
    parameter int PRIME    = FEEDER_PRIME_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [IN_WIDTH-1:0]      in_sample,
    output logic                     in_ready,
    input  logic                     ready,
    output logic [IN_WIDTH-1:0]      sample,
    output logic                     sample_fresh,
    output logic                     streaming,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underrun,
    output logic                     overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    feeder_state_t        state_reg;
    feeder_state_t        state_next;
    logic                 pop_req;
    logic                 underrun_set;
    logic [IN_WIDTH-1:0]  fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [IN_WIDTH-1:0]  sample_reg;
    logic                 sample_fresh_reg;
    logic                 underrun_reg;
    logic                 overflow_reg;

    dtree_sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop_req),
        .din   (in_sample),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready     = !fifo_full;
    assign count        = fifo_count;
    assign sample       = sample_reg;
    assign sample_fresh = sample_fresh_reg;
    assign streaming    = (state_reg == STREAM);
    assign underrun     = underrun_reg;
    assign overflow     = overflow_reg;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_reg <= FILL;
        else       state_reg <= state_next;
    end

    // Next state and pop decision; a ready on an empty FIFO (even with a
    // push in flight, as there is no bypass) is an underrun and re-primes.
    always_comb begin
        state_next   = state_reg;
        pop_req      = 1'b0;
        underrun_set = 1'b0;
        unique case (state_reg)
            FILL: begin
                if (fifo_count >= CW'(PRIME)) state_next = STREAM;
            end
            STREAM: begin
                if (ready) begin
                    if (fifo_empty) begin
                        underrun_set = 1'b1;
                        state_next   = FILL;
                    end else begin
                        pop_req = 1'b1;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Output sample register: loads the head entry at the popping edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_reg       <= '0;
            sample_fresh_reg <= 1'b0;
        end else begin
            sample_fresh_reg <= pop_req;
            if (pop_req) sample_reg <= fifo_dout;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (underrun_set)          underrun_reg <= 1'b1;
            if (in_valid && fifo_full) overflow_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dtree_sample_feeder.sv
// Directed bench for dtree_sample_feeder: priming, underrun, overflow,
// simultaneous push/pop, pointer wrap-around and mid-run reset.
module tb_dtree_sample_feeder;

    localparam int W     = 10;
    localparam int DEPTH = 16;
    localparam int PRIME = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_sample;
    logic          in_ready;
    logic          ready;
    logic [W-1:0]  sample;
    logic          sample_fresh;
    logic          streaming;
    logic [4:0]    count;
    logic          underrun;
    logic          overflow;

    int total_cnt  = 0;
    int passed_cnt = 0;
    int failed_cnt = 0;

    dtree_sample_feeder #(
        .IN_WIDTH (W),
        .DEPTH    (DEPTH),
        .PRIME    (PRIME)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_sample    (in_sample),
        .in_ready     (in_ready),
        .ready        (ready),
        .sample       (sample),
        .sample_fresh (sample_fresh),
        .streaming    (streaming),
        .count        (count),
        .underrun     (underrun),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total_cnt++;
        assert (obs === exp) begin
            passed_cnt++;
            $display("  %s obs=%0d exp=%0d", tag, obs, exp);
        end else begin
            failed_cnt++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".sample"},   32'(sample), 0);
        check({tag, ".fresh"},    32'(sample_fresh), 0);
        check({tag, ".stream"},   32'(streaming), 0);
        check({tag, ".count"},    32'(count), 0);
        check({tag, ".underrun"}, 32'(underrun), 0);
        check({tag, ".overflow"}, 32'(overflow), 0);
        check({tag, ".in_ready"}, 32'(in_ready), 1);
    endtask

    // Hard time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int np;
        int nq;
        reset = 1'b1; in_valid = 1'b0; in_sample = '0; ready = 1'b0;
        tick(); tick();
        check_idle_reset("reset");
        reset = 1'b0;

        // ---- Priming with ready held high ----
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sample = W'(10 * (i + 1));
            tick();
            check($sformatf("prime.count%0d", i), 32'(count), i + 1);
            check($sformatf("prime.sample%0d", i), 32'(sample), 0);
            check($sformatf("prime.stream%0d", i), 32'(streaming), 0);
        end
        in_valid = 1'b0;
        tick();
        check("prime.stream_rise", 32'(streaming), 1);
        check("prime.sample_hold", 32'(sample), 0);
        check("prime.count_hold", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("prime.pop%0d", i), 32'(sample), 10 * (i + 1));
            check($sformatf("prime.fresh%0d", i), 32'(sample_fresh), 1);
            check($sformatf("prime.cnt_after%0d", i), 32'(count), 3 - i);
        end
        ready = 1'b0;
        tick();
        check("prime.fresh_low", 32'(sample_fresh), 0);
        check("prime.sample_keep", 32'(sample), 40);
        check("prime.no_underrun", 32'(underrun), 0);

        // ---- Underrun: 2 entries, 3 ready pulses ----
        in_valid = 1'b1; in_sample = W'(50); tick();
        in_sample = W'(60); tick();
        in_valid = 1'b0;
        check("urun.count2", 32'(count), 2);
        ready = 1'b1;
        tick();
        check("urun.pop50", 32'(sample), 50);
        tick();
        check("urun.pop60", 32'(sample), 60);
        check("urun.empty", 32'(count), 0);
        tick();
        check("urun.flag", 32'(underrun), 1);
        check("urun.sample_hold", 32'(sample), 60);
        check("urun.fresh_low", 32'(sample_fresh), 0);
        check("urun.to_fill", 32'(streaming), 0);
        // ready stays high during re-prime: it must be ignored in FILL
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sample = W'(70 + 10 * i);
            tick();
            check($sformatf("urun.reprime_cnt%0d", i), 32'(count), i + 1);
            check($sformatf("urun.reprime_fill%0d", i), 32'(streaming), 0);
            check($sformatf("urun.reprime_hold%0d", i), 32'(sample), 60);
        end
        in_valid = 1'b0;
        tick();
        check("urun.restream", 32'(streaming), 1);
        check("urun.restream_cnt", 32'(count), 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("urun.repop%0d", i), 32'(sample), 70 + 10 * i);
        end
        ready = 1'b0;
        tick();

        // ---- Overflow: 17 pushes into a 16-deep FIFO ----
        reset = 1'b1; tick();
        check_idle_reset("rst2");
        reset = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            in_valid = 1'b1; in_sample = W'(i);
            tick();
            check($sformatf("ovf.count%0d", i), 32'(count), (i + 1 < 16) ? i + 1 : 16);
            check($sformatf("ovf.in_ready%0d", i), 32'(in_ready), (i + 1 < 16) ? 1 : 0);
            check($sformatf("ovf.flag%0d", i), 32'(overflow), (i == 16) ? 1 : 0);
        end
        in_valid = 1'b0;
        ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            tick();
            check($sformatf("ovf.pop%0d", j), 32'(sample), j);
            check($sformatf("ovf.popcnt%0d", j), 32'(count), 15 - j);
        end
        ready = 1'b0;
        tick();
        check("ovf.sticky", 32'(overflow), 1);
        check("ovf.no_underrun", 32'(underrun), 0);
        check("ovf.stream", 32'(streaming), 1);

        // ---- Simultaneous push/pop at count 5 ----
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sample = W'(200 + i);
            tick();
        end
        check("sim.count5", 32'(count), 5);
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_sample = W'(205 + k);
            tick();
            check($sformatf("sim.pop%0d", k), 32'(sample), 200 + k);
            check($sformatf("sim.cnt%0d", k), 32'(count), 5);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("sim.drain%0d", k), 32'(sample), 208 + k);
        end
        ready = 1'b0;
        tick();
        check("sim.empty", 32'(count), 0);

        // ---- Wrap-around: 100 values, push and ready each 1 in 3 cycles ----
        reset = 1'b1; tick(); reset = 1'b0;
        np = 0; nq = 0;
        for (int c = 0; c <= 310; c++) begin
            in_valid  = (c % 3 == 0) && (np < 100);
            in_sample = W'(500 + np);
            ready     = (c % 3 == 1);
            tick();
            if (in_valid) np++;
            if (ready && c >= 13) begin
                check($sformatf("wrap.pop%0d", nq), 32'(sample), 500 + nq);
                check($sformatf("wrap.fresh%0d", nq), 32'(sample_fresh), 1);
                nq++;
            end
        end
        in_valid = 1'b0; ready = 1'b0;
        tick();
        check("wrap.count0", 32'(count), 0);
        check("wrap.underrun", 32'(underrun), 0);
        check("wrap.overflow", 32'(overflow), 0);
        check("wrap.stream", 32'(streaming), 1);

        // ---- Mid-run reset at count 9 in STREAM ----
        ready = 1'b1; tick(); ready = 1'b0;
        check("mid.pre_underrun", 32'(underrun), 1);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_sample = W'(600 + i);
            tick();
        end
        in_valid = 1'b0;
        check("mid.count9", 32'(count), 9);
        check("mid.streaming", 32'(streaming), 1);
        check("mid.old_sample", 32'(sample), 599);
        reset = 1'b1; tick(); reset = 1'b0;
        check_idle_reset("mid");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sample = W'(700 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("mid.restream", 32'(streaming), 1);
        ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check($sformatf("mid.pop%0d", j), 32'(sample), 700 + j);
        end
        ready = 1'b0;
        tick();
        check("mid.final_count", 32'(count), 0);
        check("mid.final_underrun", 32'(underrun), 0);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
